// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the two-port SRAM controller.
// The optional round-robin arbitration is enabled by SRAM_CTRL_ROUND_ROBIN_EN.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PULSE,
        ST_HOLD,
        ST_RESP
    } state_t;

    localparam int SRAM_ADDR_W = 7;
    localparam int SRAM_DATA_W = 32;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sram_ctrl_arb.sv
// Two-requester arbiter producing a one-hot grant {B, A}.
// SRAM_CTRL_ROUND_ROBIN_EN: alternate on ties; otherwise port B has fixed priority.
module sram_ctrl_arb
    import sram_ctrl_pkg::*;
(
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
`endif
    input  logic       a_req,
    input  logic       b_req,
    output logic [1:0] gnt
);

`ifdef SRAM_CTRL_ROUND_ROBIN_EN
    logic last;

    // Remembers the most recently granted port; resets to B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PORT_B;
        end else if (accept) begin
            last <= gnt[1] ? PORT_B : PORT_A;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (a_req && b_req) begin
            gnt = (last == PORT_B) ? 2'b01 : 2'b10;
        end else if (a_req) begin
            gnt = 2'b01;
        end else if (b_req) begin
            gnt = 2'b10;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (b_req) begin
            gnt = 2'b10;
        end else if (a_req) begin
            gnt = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/sram_ctrl.sv
// Two-port SRAM access controller: arbitrates ports A and B and sequences
// address setup, strobe pulse, hold and response. Macro: SRAM_CTRL_ROUND_ROBIN_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int PULSE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_addr_ready,
    output logic              sram_read_pulse,
    output logic              sram_write_pulse,
    output logic [DATA_W-1:0] sram_datain,
    input  logic [DATA_W-1:0] sram_dataout
);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic       we_q;
    logic       owner_q;
    logic [1:0] arb_gnt;
    logic       accept;

    sram_ctrl_arb u_arb (
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
`endif
        .a_req  (a_req),
        .b_req  (b_req),
        .gnt    (arb_gnt)
    );

    assign accept = (state == ST_IDLE) && (a_req || b_req);
    assign a_gnt  = (state == ST_IDLE) && arb_gnt[0];
    assign b_gnt  = (state == ST_IDLE) && arb_gnt[1];
    assign a_done = (state == ST_RESP) && (owner_q == PORT_A);
    assign b_done = (state == ST_RESP) && (owner_q == PORT_B);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_ADDR;
            ST_ADDR:  next_state = ST_PULSE;
            ST_PULSE: if (cnt == 4'(PULSE_CYCLES - 1)) next_state = ST_HOLD;
            ST_HOLD:  next_state = ST_RESP;
            ST_RESP:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // SRAM-facing strobes are registered from next_state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= 4'd0;
            we_q             <= 1'b0;
            owner_q          <= PORT_A;
            sram_addr        <= '0;
            sram_datain      <= '0;
            sram_addr_ready  <= 1'b0;
            sram_read_pulse  <= 1'b0;
            sram_write_pulse <= 1'b0;
        end else begin
            state            <= next_state;
            cnt              <= (state == ST_PULSE) ? cnt + 4'd1 : 4'd0;
            sram_addr_ready  <= (next_state == ST_ADDR) || (next_state == ST_PULSE)
                                || (next_state == ST_HOLD);
            sram_read_pulse  <= (next_state == ST_PULSE) && !we_q;
            sram_write_pulse <= (next_state == ST_PULSE) && we_q;
            if (accept) begin
                we_q        <= arb_gnt[1] ? b_we : a_we;
                owner_q     <= arb_gnt[1] ? PORT_B : PORT_A;
                sram_addr   <= arb_gnt[1] ? b_addr : a_addr;
                sram_datain <= arb_gnt[1] ? b_wdata : a_wdata;
            end
        end
    end

    // Read data is captured at the end of HOLD, after the SRAM updated on the strobe's fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if ((state == ST_HOLD) && !we_q) begin
            if (owner_q == PORT_B) begin
                b_rdata <= sram_dataout;
            end else begin
                a_rdata <= sram_dataout;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: random two-port traffic against a cycle-level
// reference model, with a behavioural SRAM attached to the strobe outputs.
module tb_sram_ctrl;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int PC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_done, b_gnt, b_done;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_addr_ready, sram_read_pulse, sram_write_pulse;
    logic [DW-1:0] sram_datain, sram_dataout;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PULSE_CYCLES(PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .sram_addr(sram_addr), .sram_addr_ready(sram_addr_ready),
        .sram_read_pulse(sram_read_pulse), .sram_write_pulse(sram_write_pulse),
        .sram_datain(sram_datain), .sram_dataout(sram_dataout)
    );

    // Edge-sensitive SRAM: both reads and writes take effect on the strobe's falling edge.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(negedge sram_read_pulse) sram_dataout <= sram_mem[sram_addr];
    always @(negedge sram_write_pulse) sram_mem[sram_addr] = sram_datain;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
        logic          check_data;
        int            done_cyc;
    } exp_t;

    exp_t          sbq[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            free_cyc = 0;
    logic          rr_last = 1'b1;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            known [0:(1<<AW)-1];
    logic          exp_a_gnt = 1'b0, exp_b_gnt = 1'b0;
    bit            cur_active = 1'b0;
    int            cur_g = 0;
    logic          cur_we = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_data = '0;
    bit            mon_en = 1'b0;
    logic [AW-1:0] ra_addr, rb_addr;
    logic [DW-1:0] ra_data, rb_data;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: decides the grant for this cycle from the arbitration rule
    // and the controller's busy window, then queues the expected response.
    task automatic model_step();
        logic w;
        exp_t e;
        exp_a_gnt = 1'b0;
        exp_b_gnt = 1'b0;
        if (cyc >= free_cyc && (a_req || b_req)) begin
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
            if (a_req && b_req) w = (rr_last == 1'b1) ? 1'b0 : 1'b1;
            else w = b_req;
            rr_last = w;
`else
            w = b_req;
`endif
            if (w) exp_b_gnt = 1'b1; else exp_a_gnt = 1'b1;
            cur_active = 1'b1;
            cur_g      = cyc;
            cur_we     = w ? b_we : a_we;
            cur_addr   = w ? b_addr : a_addr;
            cur_data   = w ? b_wdata : a_wdata;
            e.port     = w;
            e.done_cyc = cyc + 3 + PC;
            e.rdata    = ref_mem[cur_addr];
            e.check_data = !cur_we && known[cur_addr];
            if (cur_we) begin
                ref_mem[cur_addr] = cur_data;
                known[cur_addr]   = 1'b1;
            end
            free_cyc = cyc + 4 + PC;
            sbq.push_back(e);
        end
    endtask

    task automatic apply_stimulus(input logic ar, input logic aw, input logic [AW-1:0] aa,
                                  input logic [DW-1:0] ad, input logic br, input logic bw,
                                  input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        @(posedge clk);
        cyc++;
        #1;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic randomize_fields();
        ra_addr = AW'($urandom_range(0, 15));
        rb_addr = AW'($urandom_range(0, 15));
        ra_data = $urandom;
        rb_data = $urandom;
    endtask

    // Monitor: every cycle compares grants and SRAM pins with the model's timing
    // window and pops the scoreboard when a completion is due or presented.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic er, rp, wp, exp_ad, exp_bd;
            er = cur_active && cyc >= cur_g + 1 && cyc <= cur_g + 2 + PC;
            rp = cur_active && !cur_we && cyc >= cur_g + 2 && cyc <= cur_g + 1 + PC;
            wp = cur_active && cur_we && cyc >= cur_g + 2 && cyc <= cur_g + 1 + PC;
            check_output("a_gnt", a_gnt, exp_a_gnt);
            check_output("b_gnt", b_gnt, exp_b_gnt);
            check_output("addr_ready", sram_addr_ready, er);
            check_output("read_pulse", sram_read_pulse, rp);
            check_output("write_pulse", sram_write_pulse, wp);
            if (er) begin
                check_output("sram_addr", sram_addr, cur_addr);
                check_output("sram_datain", sram_datain, cur_data);
            end
            exp_ad = sbq.size() > 0 && sbq[0].done_cyc == cyc && sbq[0].port == 1'b0;
            exp_bd = sbq.size() > 0 && sbq[0].done_cyc == cyc && sbq[0].port == 1'b1;
            check_output("a_done", a_done, exp_ad);
            check_output("b_done", b_done, exp_bd);
            if ((exp_ad || exp_bd || a_done || b_done) && sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                if (e.check_data && (exp_ad || exp_bd))
                    check_output(e.port ? "b_rdata" : "a_rdata", e.port ? b_rdata : a_rdata, e.rdata);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = '0;
            known[i]   = 1'b0;
        end
        #2;
        check_output("rst_addr_ready", sram_addr_ready, 1'b0);
        check_output("rst_read_pulse", sram_read_pulse, 1'b0);
        check_output("rst_write_pulse", sram_write_pulse, 1'b0);
        check_output("rst_sram_addr", sram_addr, '0);
        check_output("rst_sram_datain", sram_datain, '0);
        check_output("rst_a_rdata", a_rdata, '0);
        check_output("rst_b_rdata", b_rdata, '0);
        check_output("rst_done", {a_done, b_done}, 2'b00);
        #10 rst_n = 1'b1;
        mon_en = 1'b1;

        // Port B write followed by port A read of the same word.
        apply_stimulus(0, 0, '0, '0, 1, 1, 7'd5, 32'hDEADBEEF);
        idle_cycles(PC + 3);
        apply_stimulus(1, 0, 7'd5, 32'h0, 0, 0, '0, '0);
        idle_cycles(PC + 3);

        // Both ports held high: four back-to-back accesses exercise arbitration.
        for (int i = 0; i < 4 * (4 + PC); i++) begin
            randomize_fields();
            apply_stimulus(1, 1'($urandom_range(0, 1)), ra_addr, ra_data,
                           1, 1'($urandom_range(0, 1)), rb_addr, rb_data);
        end
        idle_cycles(PC + 4);

        for (int i = 0; i < 400; i++) begin
            randomize_fields();
            apply_stimulus(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ra_addr, ra_data,
                           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), rb_addr, rb_data);
        end
        idle_cycles(PC + 4);

        // Abort a write in its first PULSE cycle with an asynchronous reset.
        apply_stimulus(0, 0, '0, '0, 1, 1, 7'd9, 32'h12345678);
        idle_cycles(2);
        #1 rst_n = 1'b0;
        #1;
        check_output("abort_write_pulse", sram_write_pulse, 1'b0);
        check_output("abort_read_pulse", sram_read_pulse, 1'b0);
        check_output("abort_addr_ready", sram_addr_ready, 1'b0);
        check_output("abort_done", {a_done, b_done}, 2'b00);
        sbq.delete();
        cur_active = 1'b0;
        free_cyc   = cyc;
        rr_last    = 1'b1;
        known[9]   = 1'b0;
        known[0]   = 1'b0;
        exp_a_gnt  = 1'b0;
        exp_b_gnt  = 1'b0;
        #1 rst_n = 1'b1;

        apply_stimulus(1, 0, 7'd5, 32'h0, 1, 0, 7'd5, 32'h0);
        idle_cycles(PC + 3);
        for (int i = 0; i < 150; i++) begin
            randomize_fields();
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra_addr, ra_data,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb_addr, rb_data);
        end
        idle_cycles(PC + 6);
        check_output("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
